// File: rtl/rst_pkg.sv
// ---------------------------------------------------------------------------
// rst_pkg : shared FSM state type and counter-width helpers for rst_seq.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

package rst_pkg;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_HOLD     = 2'd1,
      ST_RELEASE  = 2'd2,
      ST_RUN      = 2'd3
   } state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rst_stretch.sv
// ---------------------------------------------------------------------------
// rst_stretch : per-channel saturating stretch counter for local resets.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module rst_stretch
   import rst_pkg::*;
#(
   parameter int STRETCH = 4
) (
   input  logic clk,
   input  logic sys_rstn,
   input  logic req_i,
   output logic zero_next_o
);

   localparam int CW = cnt_width(STRETCH);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (req_i) begin
         cnt_d = CW'(STRETCH);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Exposed from the next value so the top registers the output on the same edge.
   assign zero_next_o = (cnt_d == '0);

   always_ff @(posedge clk) begin
      if (!sys_rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq : multi-channel reset sequencer with staggered release.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module rst_seq
   import rst_pkg::*;
#(
   parameter int N_CH    = 3,
   parameter int STRETCH = 4,
   parameter int STAGGER = 2
) (
   input  logic            clk,
   input  logic            sys_rstn,
   input  logic            usr_rst,
   input  logic [N_CH-1:0] ch_rst_req,
   output logic [N_CH-1:0] rstn_out,
   output logic            armed,
   output logic            busy
);

   localparam int GCNT_MAX = max2(STRETCH, STAGGER);
   localparam int GCNT_W   = cnt_width(GCNT_MAX);
   localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_e            state_q, state_d;
   logic [GCNT_W-1:0] gcnt_q, gcnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              armed_q, armed_d;
   logic              busy_q, busy_d;
   logic [N_CH-1:0]   rstn_q, rstn_d;
   logic [N_CH-1:0]   lcnt_zero_d;

   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_stretch
         rst_stretch #(
            .STRETCH     (STRETCH)
         ) u_stretch (
            .clk         (clk),
            .sys_rstn    (sys_rstn),
            .req_i       (ch_rst_req[g]),
            .zero_next_o (lcnt_zero_d[g])
         );
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      idx_d   = idx_q;
      armed_d = armed_q;
      case (state_q)
         ST_DISARMED: begin
            if (usr_rst) begin
               state_d = ST_HOLD;
               armed_d = 1'b1;
               gcnt_d  = '0;
               idx_d   = '0;
            end
         end
         ST_HOLD: begin
            if (usr_rst) begin
               gcnt_d = '0;
            end else if (gcnt_q == GCNT_W'(STRETCH - 1)) begin
               gcnt_d  = '0;
               idx_d   = '0;
               state_d = (N_CH == 1) ? ST_RUN : ST_RELEASE;
            end else if (gcnt_q != GCNT_W'(GCNT_MAX)) begin
               gcnt_d = gcnt_q + GCNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (usr_rst) begin
               state_d = ST_HOLD;
               gcnt_d  = '0;
               idx_d   = '0;
            end else if (gcnt_q == GCNT_W'(STAGGER - 1)) begin
               gcnt_d = '0;
               idx_d  = idx_q + IDX_W'(1);
               // Releasing the last channel finishes the sequence on the same edge.
               if ((int'(idx_q) + 1) >= (N_CH - 1)) begin
                  state_d = ST_RUN;
               end
            end else if (gcnt_q != GCNT_W'(GCNT_MAX)) begin
               gcnt_d = gcnt_q + GCNT_W'(1);
            end
         end
         ST_RUN: begin
            if (usr_rst) begin
               state_d = ST_HOLD;
               gcnt_d  = '0;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = ST_DISARMED;
         end
      endcase

      busy_d = (state_d == ST_HOLD) || (state_d == ST_RELEASE);
      rstn_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         rstn_d[i] = ((state_d == ST_RUN) ||
                      ((state_d == ST_RELEASE) && (IDX_W'(i) <= idx_d))) &&
                     lcnt_zero_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!sys_rstn) begin
         state_q <= ST_DISARMED;
         gcnt_q  <= '0;
         idx_q   <= '0;
         armed_q <= 1'b0;
         busy_q  <= 1'b0;
         rstn_q  <= '0;
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
         idx_q   <= idx_d;
         armed_q <= armed_d;
         busy_q  <= busy_d;
         rstn_q  <= rstn_d;
      end
   end

   assign rstn_out = rstn_q;
   assign armed    = armed_q;
   assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq : directed scoreboard bench for rst_seq (N_CH=3, STRETCH=4, STAGGER=2).
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rst_seq;

   typedef struct {
      int         id;
      logic [2:0] rstn;
      logic       armed;
      logic       busy;
   } exp_t;

   logic       clk;
   logic       sys_rstn;
   logic       usr_rst;
   logic [2:0] ch_rst_req;
   logic [2:0] rstn_out;
   logic       armed;
   logic       busy;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   step   = 0;
   bit   done   = 1'b0;

   rst_seq #(
      .N_CH       (3),
      .STRETCH    (4),
      .STAGGER    (2)
   ) dut (
      .clk        (clk),
      .sys_rstn   (sys_rstn),
      .usr_rst    (usr_rst),
      .ch_rst_req (ch_rst_req),
      .rstn_out   (rstn_out),
      .armed      (armed),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs go out on the falling edge; the expectation is for the outputs after the next rising edge.
   task automatic cyc(input logic srst_n, input logic usr, input logic [2:0] req,
                      input logic [2:0] er, input logic ea, input logic eb);
      exp_t e;
      @(negedge clk);
      sys_rstn   = srst_n;
      usr_rst    = usr;
      ch_rst_req = req;
      e.id    = step;
      e.rstn  = er;
      e.armed = ea;
      e.busy  = eb;
      sb.push_back(e);
      step++;
   endtask

   // Full arm sequence from a usr_rst pulse to RUN.
   task automatic arm_seq();
      cyc(1, 1, 3'b000, 3'b000, 1, 1);
      repeat (3) cyc(1, 0, 3'b000, 3'b000, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b011, 1, 1);
      cyc(1, 0, 3'b000, 3'b011, 1, 1);
      cyc(1, 0, 3'b000, 3'b111, 1, 0);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (rstn_out !== e.rstn || armed !== e.armed || busy !== e.busy) begin
            n_fail++;
            $display("FAIL step %0d: got rstn_out=%b armed=%b busy=%b, need rstn_out=%b armed=%b busy=%b",
                     e.id, rstn_out, armed, busy, e.rstn, e.armed, e.busy);
         end
      end
   end

   initial begin
      sys_rstn   = 1'b0;
      usr_rst    = 1'b0;
      ch_rst_req = 3'b000;

      // Power-up: held in reset, then idle without arming.
      repeat (3)  cyc(0, 0, 3'b000, 3'b000, 0, 0);
      repeat (20) cyc(1, 0, 3'b000, 3'b000, 0, 0);

      // Local requests while disarmed change nothing visible.
      cyc(1, 0, 3'b111, 3'b000, 0, 0);

      // Arm and run the staggered release.
      arm_seq();
      repeat (2) cyc(1, 0, 3'b000, 3'b111, 1, 0);

      // Local reset on channel 1.
      cyc(1, 0, 3'b010, 3'b101, 1, 0);
      repeat (3) cyc(1, 0, 3'b000, 3'b101, 1, 0);
      cyc(1, 0, 3'b000, 3'b111, 1, 0);
      cyc(1, 0, 3'b000, 3'b111, 1, 0);

      // Retrigger during HOLD pushes the channel-0 release out.
      cyc(1, 1, 3'b000, 3'b000, 1, 1);
      repeat (2) cyc(1, 0, 3'b000, 3'b000, 1, 1);
      cyc(1, 1, 3'b000, 3'b000, 1, 1);
      repeat (3) cyc(1, 0, 3'b000, 3'b000, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b011, 1, 1);
      cyc(1, 0, 3'b000, 3'b011, 1, 1);
      cyc(1, 0, 3'b000, 3'b111, 1, 0);

      // usr_rst while rstn_out=011, then full replay.
      cyc(1, 1, 3'b000, 3'b000, 1, 1);
      repeat (3) cyc(1, 0, 3'b000, 3'b000, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b011, 1, 1);
      arm_seq();

      // Local request on channel 1 exactly at its release edge, plus usr_rst with a local request.
      cyc(1, 1, 3'b100, 3'b000, 1, 1);
      repeat (3) cyc(1, 0, 3'b000, 3'b000, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b010, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(1, 0, 3'b000, 3'b101, 1, 0);
      cyc(1, 0, 3'b000, 3'b101, 1, 0);
      cyc(1, 0, 3'b000, 3'b111, 1, 0);

      // System reset during HOLD: disarmed until a new usr_rst.
      cyc(1, 1, 3'b000, 3'b000, 1, 1);
      cyc(1, 0, 3'b000, 3'b000, 1, 1);
      cyc(0, 0, 3'b000, 3'b000, 0, 0);
      repeat (8) cyc(1, 0, 3'b000, 3'b000, 0, 0);

      // System reset during RELEASE.
      cyc(1, 1, 3'b000, 3'b000, 1, 1);
      repeat (3) cyc(1, 0, 3'b000, 3'b000, 1, 1);
      cyc(1, 0, 3'b000, 3'b001, 1, 1);
      cyc(0, 0, 3'b000, 3'b000, 0, 0);
      repeat (8) cyc(1, 0, 3'b000, 3'b000, 0, 0);

      // Re-arm after the abort.
      arm_seq();
      cyc(1, 0, 3'b000, 3'b111, 1, 0);

      // Let the monitor drain the queue, bounded.
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      #2;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, need 0", sb.size());
      end
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL watchdog: got timeout, need completion");
         $fatal(1, "watchdog expired");
      end
   end

endmodule

`default_nettype wire

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Parametrised multi-channel reset sequencer, successor to the single-output reset gate in the core.
- Holds every downstream domain in reset until software or the debug path arms it with a user reset.
- Stretches each reset for a programmable number of cycles, then releases the channels in a staggered order (channel 0 first).
- Supports per-channel local reset requests once the system is running.

Parameters:
- N_CH, 3: number of reset channels, at least 1.
- STRETCH, 4: minimum number of cycles a reset stays asserted after its last request, at least 1.
- STAGGER, 2: cycles between consecutive channel releases, at least 1.

Ports:
- clk  in  1  single system clock.
- sys_rstn  in  1  system reset; synchronous, active-low.
- usr_rst  in  1  global user reset request; arms the sequencer and restarts the global sequence; active-high.
- ch_rst_req  in  N_CH  per-channel local reset requests; active-high.
- rstn_out  out  N_CH  per-channel reset outputs; active-low; registered.
- armed  out  1  high once usr_rst has been seen since sys_rstn; registered.
- busy  out  1  high while the global sequence is in HOLD or RELEASE; registered.

Behaviour:
- Interface: one clock, clk. Reset sys_rstn is synchronous and active-low.
- sys_rstn low at an edge, with priority over everything:
  - state becomes DISARMED.
  - rstn_out = all zeros, armed = 0, busy = 0.
  - All counters and the channel index are cleared.
  - Reset mid-sequence aborts the sequence immediately.
- FSM states: DISARMED, HOLD, RELEASE, RUN. All outputs are derived from next-state and registered, so they change on the same edge as the state.
- DISARMED:
  - All channels held in reset.
  - usr_rst=1 -> HOLD, armed=1, busy=1. armed stays 1 until sys_rstn.
  - ch_rst_req is ignored for state, but still loads the per-channel counters.
- HOLD:
  - All rstn_out = 0.
  - Global counter gcnt: cleared while usr_rst=1, otherwise incremented.
  - gcnt==STRETCH-1 with usr_rst=0 -> RELEASE with idx=0. This releases channel 0.
  - A one-cycle usr_rst sampled at edge t gives HOLD from t+1, and rstn_out[0] rises at t+1+STRETCH.
- RELEASE:
  - Channels with index <= idx are globally released; the rest stay held.
  - gcnt counts STAGGER cycles, then idx increments and the next channel is released.
  - Releasing channel N_CH-1 moves the FSM to RUN in the same edge, and busy falls.
  - usr_rst=1 -> HOLD, all channels reasserted at the next edge, gcnt=0.
  - If N_CH=1, RUN is entered together with the channel-0 release.
- RUN:
  - busy=0.
  - usr_rst=1 -> HOLD, all rstn_out=0 at the next edge.
- Per-channel stretch counter lcnt[i], width $clog2(STRETCH+1):
  - ch_rst_req[i]=1 loads STRETCH.
  - Otherwise the counter decrements, saturating at 0.
  - Active in all states except during sys_rstn.
- Output equation: rstn_out[i] = globally released(i) AND (next lcnt[i]==0).
  - A single-cycle request at edge t in RUN drives rstn_out[i] low from t+1 to t+STRETCH inclusive, then high at t+STRETCH+1.
  - A held request keeps the channel low for STRETCH cycles after its last sampled high.
- Simultaneous events:
  - A local request on a channel during its release edge wins: the channel stays low.
  - usr_rst together with ch_rst_req: both take effect.
  - The global counter is never affected by local requests.
- Width rules:
  - gcnt width is $clog2(max(STRETCH,STAGGER)+1).
  - idx width is max(1,$clog2(N_CH)).
  - No wrap-around: counters are compared and saturated, never overflowed.

Decomposition:
- Shared package rst_pkg:
  - FSM state enum: DISARMED, HOLD, RELEASE, RUN.
  - Width helper function for counter sizing.
- Sub-module rst_stretch: one per-channel saturating stretch counter, parametrised by STRETCH. Instantiated N_CH times via generate.
- The top level holds the FSM, gcnt, idx and the output registers.

Test Plan (N_CH=3, STRETCH=4, STAGGER=2):
- Power-up: sys_rstn low for 3 cycles, then high, no usr_rst for 20 cycles -> rstn_out=3'b000, armed=0, busy=0 throughout.
- Arm: one-cycle usr_rst at edge t ->
  - armed and busy high from t+1.
  - rstn_out = 001 at t+5, 011 at t+7, 111 at t+9.
  - busy=0 at t+9.
- Retrigger: usr_rst high at t and again at t+3 -> rstn_out[0] rises at t+8, not t+5.
- Local reset: in RUN, ch_rst_req=3'b010 for 1 cycle at t -> rstn_out=101 during t+1..t+4, 111 at t+5; other channels never glitch.
- Global during RELEASE: usr_rst at the edge where rstn_out=011 -> 000 next edge, then the full sequence replays with the same spacing.
- Reset mid-sequence: sys_rstn low at an edge during HOLD or RELEASE -> rstn_out=000, armed=0, busy=0 at that edge; the sequencer stays DISARMED until a new usr_rst.
